quad_decoder_n: RTL and testbench
=================================

Name: quad_decoder_n

Overview:
Parametrised successor to the single-purpose quad timer inputs of crt_sys. Decodes NCH quadrature encoder channels (A/B pairs) at 4x resolution into wrapping up/down counters.
- Per-channel glitch filter, illegal-transition detection, coherent byte-wide snapshot reads over the 8-bit host bus, and a maskable interrupt.
- Sits between the JAMMA spinner/trackball inputs and the host register decoder in crt_sys.

Parameters:
NCH, 4, number of quadrature channels (1..8)
CNT_W, 16, counter width in bits (9..16; read as two bytes, high byte zero-extended)
FILT_LEN, 3, consecutive equal synchronised samples needed to accept a new input level (1..15)
CH_W, 2, width of ch_sel; must be at least clog2(NCH), minimum 1

Ports:
clk      in   1        system clock
reset    in   1        synchronous reset, active-high
a        in   NCH      channel A inputs, asynchronous
b        in   NCH      channel B inputs, asynchronous
ch_sel   in   CH_W     host channel select
reg_sel  in   2        0=count low, 1=count high, 2=status, 3=control
rd       in   1        single-cycle read strobe
wr       in   1        single-cycle write strobe
wdata    in   8        write data
rdata    out  8        read data, registered
irq      out  1        interrupt, level, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- On reset:
  - counters, snapshots and sticky flags = 0
  - irq_en = 0, rdata = 0, irq = 0
  - sync and filter registers = 0; filtered state = 00
- Input path, per bit: 2-FF synchroniser, then filter counter.
  - The filtered level changes only after the synchronised level has differed from it for FILT_LEN consecutive cycles.
  - Any sample equal to the current filtered level resets the filter counter.
- Decode, per channel: compare the filtered {A,B} with its previous value one cycle later.
  - 00->01->11->10->00 = +1 (up)
  - reverse sequence = -1 (down)
  - no change = hold
  - both bits change = illegal: err set sticky, count unchanged
- Latency: an input edge stable from cycle 0 updates the count at cycle 2+FILT_LEN+1 (FILT_LEN=3: cycle 6).
- Counter arithmetic: modulo 2^CNT_W. 0 - 1 = 2^CNT_W-1; max + 1 = 0; no saturation.
- Each count step:
  - sets changed (sticky)
  - sets dir (1 = last step up, 0 = down; not sticky, held until the next step)
- Host reads (rd with reg_sel/ch_sel decoded in the same cycle; rdata valid the cycle after rd and held until the next rd):
  - reg 0: returns count[7:0] and copies the full count into snap[ch] in the same cycle. The pre-increment value is returned and latched if a step coincides.
  - reg 1: returns snap[ch][CNT_W-1:8], zero-extended. Does not re-latch.
  - reg 2: returns {5'b0, err, dir, changed} and clears changed for that channel. If a count step occurs in the same cycle, changed remains 1 (set wins).
  - reg 3: returns {5'b0, irq_en, 2'b0}
  - ch_sel >= NCH: rdata = 0, no side effects
- Host writes (reg 3 only; writes to regs 0-2 are ignored):
  - wdata[0] = clear count to 0. Clear wins over a same-cycle step; changed is not set.
  - wdata[1] = clear err. A same-cycle illegal transition wins (err stays 1).
  - wdata[2] = irq_en for that channel
  - bits 0/1 are self-clearing actions; bit 2 is stored
- rd and wr asserted in the same cycle: wr is performed, rd is ignored, rdata holds.
- irq = registered OR over channels of (changed & irq_en). Deasserts the cycle after the last contributing changed is cleared.
- Reset mid-operation: all state returns to reset values, including pending filter counts; no count step is generated by the reset itself.

Decomposition:
- Package quad_decoder_pkg holds:
  - register select constants REG_CNT_LO=0, REG_CNT_HI=1, REG_STAT=2, REG_CTRL=3
  - status/control bit positions
  - the decode function: prev/cur 2-bit state -> {up, down, illegal}
- One sub-module, quad_channel, is instantiated NCH times via generate. It contains the synchroniser, filter, decode, counter, snapshot and sticky flags.
- The top level owns the host mux, the rdata register and the irq OR.

Test Plan:
1. Reset, FILT_LEN=3. Drive 10 full forward cycles (40 edges, 8 cycles apart) on ch0 -> read reg0 then reg1: 0x28, 0x00; status = 0x03; irq stays 0 with irq_en=0.
2. From count 0, one backward step on ch1 -> count = 0xFFFF; reg0 returns 0xFF. Then one step forward, then read reg1 -> 0xFF (snapshot, not live 0x00).
3. A/B glitch of 2 cycles (< FILT_LEN) on ch2 -> no count change, changed=0. Simultaneous A and B toggle held 5 cycles -> status err=1 and count unchanged. Write reg3 = 0x02 -> err=0.
4. Set irq_en (reg3 = 0x04) on ch3, one step -> irq=1 within 2 cycles after the count update. Status read -> changed=0 and irq=0 the following cycle.
5. Count step coinciding with a reg3 = 0x01 write -> count=0, changed unchanged. Step coinciding with a status read -> changed remains 1.
6. Assert reset mid-sequence at count 0x0123 -> next cycle all reads return 0 and irq=0. Read with ch_sel=NCH -> rdata=0.

Source files
------------

// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: host register map,
// status/control bit positions and the quadrature step decoder.
package quad_decoder_pkg;

    // Host register select values
    localparam logic [1:0] REG_CNT_LO = 2'd0;
    localparam logic [1:0] REG_CNT_HI = 2'd1;
    localparam logic [1:0] REG_STAT   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // Status register bit positions
    localparam int STAT_CHANGED = 0;
    localparam int STAT_DIR     = 1;
    localparam int STAT_ERR     = 2;

    // Control register bit positions
    localparam int CTRL_CLR_CNT = 0;
    localparam int CTRL_CLR_ERR = 1;
    localparam int CTRL_IRQ_EN  = 2;

    // Result of comparing two consecutive filtered {A,B} states
    typedef struct packed {
        logic up;
        logic down;
        logic illegal;
    } step_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00 on {A,B}; the reverse
    // order counts down, and a change of both bits at once is illegal.
    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t s;
        s = '0;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s.up      = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s.down    = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s.illegal = 1'b1;
            default:                                 s        = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/quad_decoder_n_channel.sv
// One quadrature channel: input synchroniser and glitch filter for A and B,
// step decoder, wrapping counter, read snapshot and sticky status flags.
module quad_channel
    import quad_decoder_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       snap_ld,     // count-low read: latch full count
    input  logic       stat_rd,     // status read: clear changed
    input  logic       clr_cnt,
    input  logic       clr_err,
    input  logic       irq_en_ld,
    input  logic       irq_en_val,
    output logic [7:0] count_lo,
    output logic [7:0] snap_hi,
    output logic       err,
    output logic       dir,
    output logic       changed,
    output logic       irq_en
);

    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

    logic [1:0]       sync1, sync2;   // bit 1 = A, bit 0 = B
    logic [1:0]       filt, filt_prev;
    logic [1:0][3:0]  filt_cnt;
    logic [CNT_W-1:0] count, snap;
    step_t            st;
    logic             take_step;
    logic             unused_snap_lo;

    // Two-flop synchroniser for the asynchronous encoder inputs
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value; blocking here would collapse the two stages into one.
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {a, b};
            sync2 <= sync1;
        end
    end

    // Glitch filter: accept a new level only after FILT_LEN differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            filt      <= '0;
            filt_prev <= '0;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FILT_MAX) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign st        = decode_step(filt_prev, filt);
    assign take_step = (st.up | st.down) & ~clr_cnt;

    // Counter, snapshot and flags; a clear suppresses a coincident step
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            snap    <= '0;
            err     <= 1'b0;
            dir     <= 1'b0;
            changed <= 1'b0;
            irq_en  <= 1'b0;
        end else begin
            if (snap_ld)
                snap <= count;

            if (clr_cnt)
                count <= '0;
            else if (st.up)
                count <= count + 1'b1;
            else if (st.down)
                count <= count - 1'b1;

            if (take_step) begin
                dir     <= st.up;
                changed <= 1'b1;
            end else if (stat_rd) begin
                changed <= 1'b0;
            end

            if (st.illegal)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;

            if (irq_en_ld)
                irq_en <= irq_en_val;
        end
    end

    assign count_lo       = count[7:0];
    assign snap_hi        = 8'(snap[CNT_W-1:8]);
    assign unused_snap_lo = ^snap[7:0];

endmodule

// File: rtl/quad_decoder_n.sv
// NCH-channel quadrature decoder with an 8-bit host register interface,
// registered read data and a maskable level interrupt.
module quad_decoder_n
    import quad_decoder_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3,
    parameter int CH_W     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  a,
    input  logic [NCH-1:0]  b,
    input  logic [CH_W-1:0] ch_sel,
    input  logic [1:0]      reg_sel,
    input  logic            rd,
    input  logic            wr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    output logic            irq
);

    logic [7:0]     count_lo [NCH];
    logic [7:0]     snap_hi  [NCH];
    logic [NCH-1:0] err_v, dir_v, changed_v, irq_en_v;
    logic           rd_ok;
    logic [7:0]     rd_val;
    logic           unused_wdata;

    // A write takes priority over a simultaneous read
    assign rd_ok        = rd & ~wr;
    assign unused_wdata = ^wdata[7:3];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel, ctrl_wr;
        assign sel     = (ch_sel == CH_W'(i));
        assign ctrl_wr = sel & wr & (reg_sel == REG_CTRL);

        quad_channel #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .a          (a[i]),
            .b          (b[i]),
            .snap_ld    (sel & rd_ok & (reg_sel == REG_CNT_LO)),
            .stat_rd    (sel & rd_ok & (reg_sel == REG_STAT)),
            .clr_cnt    (ctrl_wr & wdata[CTRL_CLR_CNT]),
            .clr_err    (ctrl_wr & wdata[CTRL_CLR_ERR]),
            .irq_en_ld  (ctrl_wr),
            .irq_en_val (wdata[CTRL_IRQ_EN]),
            .count_lo   (count_lo[i]),
            .snap_hi    (snap_hi[i]),
            .err        (err_v[i]),
            .dir        (dir_v[i]),
            .changed    (changed_v[i]),
            .irq_en     (irq_en_v[i])
        );
    end

    // Read mux; an out-of-range ch_sel matches no channel and reads zero
    always_comb begin
        // NOTE: default assignment first so every path drives rd_val and no
        // latch is inferred.
        rd_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_CNT_LO: rd_val = count_lo[i];
                    REG_CNT_HI: rd_val = snap_hi[i];
                    REG_STAT: begin
                        rd_val[STAT_CHANGED] = changed_v[i];
                        rd_val[STAT_DIR]     = dir_v[i];
                        rd_val[STAT_ERR]     = err_v[i];
                    end
                    default:    rd_val[CTRL_IRQ_EN] = irq_en_v[i];
                endcase
            end
        end
    end

    // Registered read data and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
            irq   <= 1'b0;
        end else begin
            if (rd_ok)
                rdata <= rd_val;
            irq <= |(changed_v & irq_en_v);
        end
    end

endmodule

// File: tb/tb_quad_decoder_n.sv
// Directed testbench for quad_decoder_n: table-driven register reads plus
// hand-written sequences for timing-sensitive corner cases.
module tb_quad_decoder_n;

    localparam int NCH      = 4;
    localparam int CNT_W    = 16;
    localparam int FILT_LEN = 3;
    localparam int CH_W     = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  a, b;
    logic [CH_W-1:0] ch_sel;
    logic [1:0]      reg_sel;
    logic            rd, wr;
    logic [7:0]      wdata;
    logic [7:0]      rdata;
    logic            irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         ch;
        int         rs;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t t1 [6];

    quad_decoder_n #(
        .NCH      (NCH),
        .CNT_W    (CNT_W),
        .FILT_LEN (FILT_LEN),
        .CH_W     (CH_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .ch_sel  (ch_sel),
        .reg_sel (reg_sel),
        .rd      (rd),
        .wr      (wr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] next_state(input logic [1:0] s, input logic up);
        logic [1:0] n;
        if (up)
            case (s)
                2'b00: n = 2'b01;
                2'b01: n = 2'b11;
                2'b11: n = 2'b10;
                default: n = 2'b00;
            endcase
        else
            case (s)
                2'b00: n = 2'b10;
                2'b10: n = 2'b11;
                2'b11: n = 2'b01;
                default: n = 2'b00;
            endcase
        return n;
    endfunction

    // Move one channel to its next quadrature state at a falling edge
    task automatic drive_step(input int ch, input logic up);
        logic [1:0] s;
        @(negedge clk);
        s     = next_state({a[ch], b[ch]}, up);
        a[ch] = s[1];
        b[ch] = s[0];
    endtask

    task automatic step(input int ch, input logic up);
        drive_step(ch, up);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_read(input int ch, input int rs, output logic [7:0] val);
        @(negedge clk);
        ch_sel  = CH_W'(ch);
        reg_sel = 2'(rs);
        rd      = 1'b1;
        @(negedge clk);
        rd  = 1'b0;
        val = rdata;
    endtask

    task automatic do_write(input int ch, input int rs, input logic [7:0] d);
        @(negedge clk);
        ch_sel  = CH_W'(ch);
        reg_sel = 2'(rs);
        wdata   = d;
        wr      = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
        wdata = '0;
    endtask

    initial begin
        logic [7:0] v;
        int         n;

        t1[0] = '{0, 0, 8'h28};
        t1[1] = '{0, 1, 8'h00};
        t1[2] = '{0, 2, 8'h03};
        t1[3] = '{0, 3, 8'h00};
        t1[4] = '{1, 0, 8'h00};
        t1[5] = '{1, 2, 8'h00};

        reset = 1'b1; a = '0; b = '0; ch_sel = '0; reg_sel = '0;
        rd = 1'b0; wr = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata, 8'h00);
        check("reset_irq", 8'(irq), 8'h00);

        // 1: ten full forward cycles on ch0
        for (int i = 0; i < 40; i++) step(0, 1'b1);
        foreach (t1[i]) begin
            do_read(t1[i].ch, t1[i].rs, v);
            check($sformatf("t1_vec%0d", i), v, t1[i].exp);
        end
        check("t1_irq_masked", 8'(irq), 8'h00);
        do_write(0, 0, 8'h01);
        do_read(0, 0, v);
        check("t1_wr_reg0_ignored", v, 8'h28);

        // 2: wrap below zero on ch1, snapshot holds the high byte
        step(1, 1'b0);
        do_read(1, 0, v);  check("t2_lo_ffff", v, 8'hFF);
        do_read(1, 1, v);  check("t2_hi_ffff", v, 8'hFF);
        do_read(1, 2, v);  check("t2_stat_down", v, 8'h01);
        step(1, 1'b1);
        do_read(1, 1, v);  check("t2_hi_snapshot", v, 8'hFF);
        do_read(1, 0, v);  check("t2_lo_wrap0", v, 8'h00);
        do_read(1, 2, v);  check("t2_stat_up", v, 8'h03);

        // 3: short glitches rejected, double toggle flagged illegal
        @(negedge clk); a[2] = 1'b1;
        repeat (2) @(negedge clk); a[2] = 1'b0;
        @(negedge clk); b[2] = 1'b1;
        repeat (2) @(negedge clk); b[2] = 1'b0;
        repeat (10) @(negedge clk);
        do_read(2, 0, v);  check("t3_glitch_cnt", v, 8'h00);
        do_read(2, 2, v);  check("t3_glitch_stat", v, 8'h00);
        @(negedge clk); a[2] = 1'b1; b[2] = 1'b1;
        repeat (10) @(negedge clk);
        do_read(2, 2, v);  check("t3_illegal_stat", v, 8'h04);
        do_read(2, 0, v);  check("t3_illegal_cnt", v, 8'h00);
        do_write(2, 3, 8'h02);
        do_read(2, 2, v);  check("t3_err_cleared", v, 8'h00);

        // 4: interrupt on ch3
        do_write(3, 3, 8'h04);
        do_read(3, 3, v);  check("t4_ctrl_rd", v, 8'h04);
        check("t4_irq_idle", 8'(irq), 8'h00);
        drive_step(3, 1'b1);
        n = 0;
        while (!irq && n < 15) begin
            @(negedge clk);
            n++;
        end
        check("t4_irq_latency_ok", 8'(n == 7 || n == 8), 8'h01);
        do_read(3, 2, v);  check("t4_stat", v, 8'h03);
        @(negedge clk);
        check("t4_irq_cleared", 8'(irq), 8'h00);
        do_read(3, 0, v);  check("t4_cnt", v, 8'h01);

        // 5a: clear write coincides with a step
        drive_step(3, 1'b1);
        repeat (5) @(negedge clk);
        ch_sel = CH_W'(3); reg_sel = 2'd3; wdata = 8'h01; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; wdata = '0;
        repeat (4) @(negedge clk);
        do_read(3, 0, v);  check("t5_clr_cnt", v, 8'h00);
        do_read(3, 2, v);  check("t5_clr_stat", v, 8'h02);

        // 5b: status read coincides with a down step
        drive_step(3, 1'b0);
        repeat (5) @(negedge clk);
        ch_sel = CH_W'(3); reg_sel = 2'd2; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("t5_rd_pre_step", rdata, 8'h02);
        repeat (3) @(negedge clk);
        do_read(3, 2, v);  check("t5_changed_kept", v, 8'h01);
        do_read(3, 0, v);  check("t5_cnt_ffff", v, 8'hFF);

        // 6: run ch0 to 0x0123, out-of-range select, rd+wr, then reset
        for (int i = 0; i < 251; i++) step(0, 1'b1);
        do_read(0, 0, v);  check("t6_lo_23", v, 8'h23);
        do_read(0, 1, v);  check("t6_hi_01", v, 8'h01);
        do_read(NCH, 0, v); check("t6_bad_ch", v, 8'h00);
        do_read(0, 0, v);  check("t6_lo_again", v, 8'h23);
        @(negedge clk);
        ch_sel = CH_W'(0); reg_sel = 2'd3; wdata = 8'h04; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; wdata = '0;
        check("t6_rdwr_hold", rdata, 8'h23);
        repeat (2) @(negedge clk);
        check("t6_irq_set", 8'(irq), 8'h01);

        @(negedge clk); a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_irq", 8'(irq), 8'h00);
        check("t6_rst_rdata", rdata, 8'h00);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) begin
                do_read(c, (r + 1) % 4, v);
                check($sformatf("t6_rst_ch%0d_reg%0d", c, (r + 1) % 4), v, 8'h00);
            end
        repeat (10) @(negedge clk);
        do_read(0, 0, v);  check("t6_no_step_cnt", v, 8'h00);
        do_read(0, 2, v);  check("t6_no_step_stat", v, 8'h00);
        check("t6_irq_quiet", 8'(irq), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
